// File: rtl/ahb2_sram_slv.sv
`default_nettype none
// ============================================================================
// Module      : ahb2_sram_slv
// Description : AHB-Lite slave fronting a 2^ADDR_W x 32-bit SRAM. It supports
//               byte, halfword and word transfers, and answers illegal
//               transfers with a two-cycle ERROR response. Wait states are
//               optional and enabled by the AHB2_SRAM_WAIT_EN macro.
//               Without the macro every legal transfer is zero-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb2_sram_slv #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyi,
    output logic [31:0] hrdata,
    output logic        hreadyo,
    output logic [1:0]  hresp
);

    localparam int          c_DEPTH = 1 << ADDR_W;
    localparam logic [1:0]  c_OKAY  = 2'b00;
    localparam logic [1:0]  c_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W+1:0]   r_addr;
    logic                r_write;
    logic [1:0]          r_size;
    logic [31:0]         r_mem [c_DEPTH];

    logic                w_accept;
    logic                w_legal;
    logic                w_done;
    logic                w_commit;
    logic [3:0]          w_be;
    logic [ADDR_W-1:0]   w_widx;
    logic                w_unused;

    // Bursts are treated beat by beat, so hburst/hprot carry no meaning here.
    assign w_unused = ^{hburst, hprot};

    // A new address phase is only sampled while this slave is itself ready.
    assign w_accept = hsel & hreadyi & htrans[1] & hreadyo;
    assign w_widx   = r_addr[ADDR_W+1:2];

    // Legality of the transfer in the current address phase.
    always_comb begin
        w_legal = 1'b1;
        if (hsize > 3'b010)
            w_legal = 1'b0;
        if ((hsize == 3'b001) && haddr[0])
            w_legal = 1'b0;
        if ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
            w_legal = 1'b0;
        if (haddr[31:ADDR_W+2] != '0)
            w_legal = 1'b0;
    end

`ifdef AHB2_SRAM_WAIT_EN
    logic [3:0] r_cnt;

    assign w_done = (r_cnt == 4'd0);

    // Wait-state counter: loaded on a legal accept, counts down during XFER.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)
            r_cnt <= 4'd0;
        else if (w_accept && w_legal)
            r_cnt <= 4'(WAIT_CYCLES);
        else if ((r_state == ST_XFER) && (r_cnt != 4'd0))
            r_cnt <= r_cnt - 4'd1;
    end
`else
    logic w_unused_wait;

    // WAIT_CYCLES has no effect in the zero-wait build.
    assign w_unused_wait = ^4'(WAIT_CYCLES);
    assign w_done        = 1'b1;
`endif

    // Slave response for the data phase in progress.
    always_comb begin
        hreadyo = 1'b1;
        hresp   = c_OKAY;
        case (r_state)
            ST_XFER: hreadyo = w_done;
            ST_ERR1: begin
                hreadyo = 1'b0;
                hresp   = c_ERROR;
            end
            ST_ERR2: hresp = c_ERROR;
            default: ;
        endcase
    end

    // Next state: ERR1 always moves on; any ready cycle samples the next transfer.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_ERR1)
            w_state_nxt = ST_ERR2;
        else if (hreadyo) begin
            if (w_accept)
                w_state_nxt = w_legal ? ST_XFER : ST_ERR1;
            else
                w_state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Data-phase copy of the accepted address-phase controls.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 2'b00;
        end else if (w_accept) begin
            r_addr  <= haddr[ADDR_W+1:0];
            r_write <= hwrite;
            r_size  <= hsize[1:0];
        end
    end

    // Little-endian byte-lane selection from latched size and low address bits.
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'b00:   w_be[r_addr[1:0]] = 1'b1;
            2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // A write lands only on the edge that completes its data phase, so a reset
    // during the wait states drops it.
    assign w_commit = (r_state == ST_XFER) && w_done && r_write;

    // SRAM array, byte-lane write; contents are deliberately not reset.
    always_ff @(posedge hclk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k])
                    r_mem[w_widx][8*k +: 8] <= hwdata[8*k +: 8];
            end
        end
    end

    // Asynchronous read makes a write immediately visible to a following read.
    assign hrdata = ((r_state == ST_XFER) && !r_write) ? r_mem[w_widx] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb2_sram_slv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ahb2_sram_slv
// Description : Self-checking bench for ahb2_sram_slv. A transfer-level model
//               predicts per-cycle hreadyo/hresp/hrdata; literal expectations
//               pin the model on the directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2_sram_slv;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
`ifdef AHB2_SRAM_WAIT_EN
    localparam int W = WAIT_CYCLES;
`else
    localparam int W = 0;
`endif

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    logic        hclk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b000;
    logic [2:0]  hburst = 3'b000;
    logic [3:0]  hprot = 4'b0000;
    logic [31:0] hwdata = 32'h0;
    logic        hreadyi;
    logic        rdyi_low = 1'b0;
    logic [31:0] hrdata;
    logic        hreadyo;
    logic [1:0]  hresp;

    // Single-slave bus: HREADY loops back unless a case forces it low.
    assign hreadyi = rdyi_low ? 1'b0 : hreadyo;

    ahb2_sram_slv #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hwdata(hwdata), .hreadyi(hreadyi),
        .hrdata(hrdata), .hreadyo(hreadyo), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rl;
    } xfer_t;

    typedef enum int {DP_NONE, DP_OK, DP_ERR} dp_e;

    xfer_t       q[$];
    logic [31:0] mmem [int];
    dp_e         dp_kind = DP_NONE;
    int          dp_left = 0;
    xfer_t       dp_x;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_valid = 1'b0;
    logic        exp_ready = 1'b1;
    logic [1:0]  exp_resp = 2'b00;
    logic        exp_chk_rd = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_rd_done = 1'b0;
    logic        exp_legal = 1'b0;
    logic [31:0] last_rd = 32'h0;
    int          n_wait_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input xfer_t x);
        if (x.size > 3'd2) return 1'b0;
        if (x.size == 3'd1 && x.addr[0]) return 1'b0;
        if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b0;
        if ((x.addr >> (ADDR_W + 2)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    // Memory word after a legal write: replace the 1<<size bytes starting at addr[1:0].
    function automatic logic [31:0] merge(input logic [31:0] old, input xfer_t x);
        logic [31:0] r = old;
        int base = int'(x.addr[1:0]);
        int nb   = 1 << x.size;
        for (int k = base; k < base + nb; k++) r[8*k +: 8] = x.wdata[8*k +: 8];
        return r;
    endfunction

    task automatic push(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input logic rl = 1'b0);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz;
        x.addr = a; x.wdata = d; x.rl = rl;
        q.push_back(x);
    endtask

    task automatic idle_inputs();
        hsel = 1'b0; htrans = T_IDLE; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'b000; hwdata = 32'h0; rdyi_low = 1'b0;
    endtask

    // Plays the queue as a pipelined AHB master and predicts every cycle.
    task automatic run_queue();
        xfer_t hd;
        bit    have;
        int    guard = 0;
        dp_kind = DP_NONE;
        while ((q.size() != 0 || dp_kind != DP_NONE) && guard < 1000) begin
            guard++;
            have = (q.size() != 0);
            hd = have ? q[0] : '0;
            hsel = hd.sel; htrans = hd.trans; haddr = hd.addr; hwrite = hd.wr;
            hsize = hd.size; rdyi_low = hd.rl;
            hwdata = (dp_kind == DP_OK && dp_x.wr) ? dp_x.wdata : 32'h0;
            exp_legal = 1'b0; exp_chk_rd = 1'b0; exp_rd_done = 1'b0; exp_rdata = 32'h0;
            case (dp_kind)
                DP_OK: begin
                    exp_ready = (dp_left == 0);
                    exp_resp  = 2'b00;
                    exp_legal = 1'b1;
                    if (!dp_x.wr && mmem.exists(widx(dp_x.addr))) begin
                        exp_chk_rd  = 1'b1;
                        exp_rdata   = mmem[widx(dp_x.addr)];
                        exp_rd_done = exp_ready;
                    end
                end
                DP_ERR: begin
                    exp_ready  = (dp_left == 1);
                    exp_resp   = 2'b01;
                    exp_chk_rd = 1'b1;
                end
                default: begin
                    exp_ready  = 1'b1;
                    exp_resp   = 2'b00;
                    exp_chk_rd = 1'b1;
                end
            endcase
            exp_valid = 1'b1;
            @(posedge hclk);
            #1;
            if (exp_ready) begin
                if (dp_kind == DP_OK && dp_x.wr)
                    mmem[widx(dp_x.addr)] = merge(mmem.exists(widx(dp_x.addr)) ?
                                                  mmem[widx(dp_x.addr)] : 32'h0, dp_x);
                dp_kind = DP_NONE;
                if (have) begin
                    void'(q.pop_front());
                    if (hd.sel && hd.trans[1] && !hd.rl) begin
                        dp_x = hd;
                        if (is_legal(hd)) begin
                            dp_kind = DP_OK;
                            dp_left = W;
                        end else begin
                            dp_kind = DP_ERR;
                            dp_left = 0;
                        end
                    end
                end
            end else begin
                dp_left = (dp_kind == DP_OK) ? dp_left - 1 : dp_left + 1;
            end
        end
        exp_valid = 1'b0;
        idle_inputs();
        if (guard >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_queue: got no completion expected completion within 1000 cycles");
            q.delete();
        end
    endtask

    // Compare process: DUT outputs against the model on every predicted cycle.
    always @(negedge hclk) begin
        if (exp_valid) begin
            chk("hreadyo", {31'b0, hreadyo}, {31'b0, exp_ready});
            chk("hresp", {30'b0, hresp}, {30'b0, exp_resp});
            if (exp_chk_rd) chk("hrdata", hrdata, exp_rdata);
            if (exp_legal && !hreadyo) n_wait_seen++;
            if (exp_rd_done) last_rd = hrdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        hreset_n = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hreadyo", {31'b0, hreadyo}, 32'h1);
        chk("rst_hresp", {30'b0, hresp}, 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        hreset_n = 1'b1;
        @(posedge hclk);
        #1;

        // Case 1: word write then read of the same word
        n_wait_seen = 0;
        push(1, T_NS, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        push(1, T_NS, 0, 3'd2, 32'h10, 32'h0);
        run_queue();
        chk("case1_rdata", last_rd, 32'hDEADBEEF);
        chk("case1_waits", 32'(n_wait_seen), 32'(2 * W));

        // Case 2: byte and halfword lane writes
        push(1, T_NS, 1, 3'd2, 32'h10, 32'h11223344);
        push(1, T_NS, 1, 3'd0, 32'h13, 32'hAA556677);
        push(1, T_NS, 0, 3'd2, 32'h10, 32'h0);
        run_queue();
        chk("case2_byte", last_rd, 32'hAA223344);
        push(1, T_NS, 1, 3'd2, 32'h14, 32'h01020304);
        push(1, T_NS, 1, 3'd1, 32'h16, 32'hBEEFCAFE);
        push(1, T_NS, 0, 3'd2, 32'h14, 32'h0);
        run_queue();
        chk("case2_half", last_rd, 32'hBEEF0304);

        // Case 4: NONSEQ+SEQ write burst then read burst
        n_wait_seen = 0;
        push(1, T_NS,  1, 3'd2, 32'h0, 32'h11111111);
        push(1, T_SEQ, 1, 3'd2, 32'h4, 32'h22222222);
        push(1, T_SEQ, 1, 3'd2, 32'h8, 32'h33333333);
        push(1, T_NS,  0, 3'd2, 32'h0, 32'h0);
        push(1, T_SEQ, 0, 3'd2, 32'h4, 32'h0);
        push(1, T_SEQ, 0, 3'd2, 32'h8, 32'h0);
        run_queue();
        chk("case4_last", last_rd, 32'h33333333);
        chk("case4_waits", 32'(n_wait_seen), 32'(6 * W));

        // Case 3: illegal transfers aliasing onto words 0..2, then read back
        push(1, T_NS, 1, 3'd2, 32'h02, 32'hFFFFFFFF);
        push(1, T_NS, 1, 3'd2, 32'h00001000, 32'hFFFFFFFF);
        push(1, T_NS, 1, 3'd1, 32'h05, 32'hFFFFFFFF);
        push(1, T_NS, 1, 3'd3, 32'h08, 32'hFFFFFFFF);
        push(1, T_NS, 0, 3'd2, 32'h08, 32'h0);
        push(1, T_NS, 0, 3'd2, 32'h04, 32'h0);
        push(1, T_NS, 0, 3'd2, 32'h00, 32'h0);
        run_queue();
        chk("case3_word0", last_rd, 32'h11111111);

        // Non-accepted address phases: BUSY/IDLE selected, deselected NONSEQ
        push(1, T_BUSY, 1, 3'd2, 32'h0, 32'hFFFFFFFF);
        push(1, T_IDLE, 1, 3'd2, 32'h0, 32'hFFFFFFFF);
        push(0, T_NS,   1, 3'd2, 32'h0, 32'hFFFFFFFF);
        push(1, T_NS,   0, 3'd2, 32'h0, 32'h0);
        run_queue();
        chk("noaccept_word0", last_rd, 32'h11111111);

        // Case 5a: hreadyi low ignores a selected NONSEQ write
        push(1, T_NS, 1, 3'd2, 32'h10, 32'h12345678, 1'b1);
        push(1, T_NS, 0, 3'd2, 32'h10, 32'h0);
        run_queue();
        chk("case5_rdyi_low", last_rd, 32'hAA223344);

        // Reset during ERR1 returns outputs to reset values at once
        hsel = 1; htrans = T_NS; hwrite = 1; hsize = 3'd2; haddr = 32'h02;
        @(posedge hclk);
        #1;
        idle_inputs();
        chk("err1_hreadyo", {31'b0, hreadyo}, 32'h0);
        chk("err1_hresp", {30'b0, hresp}, 32'h1);
        #2 hreset_n = 1'b0;
        #1;
        chk("rst_err_hreadyo", {31'b0, hreadyo}, 32'h1);
        chk("rst_err_hresp", {30'b0, hresp}, 32'h0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        @(posedge hclk);
        #1;

        // Case 5b: reset during a write data phase drops the write
        push(1, T_NS, 1, 3'd2, 32'h18, 32'h0BADF00D);
        run_queue();
        hsel = 1; htrans = T_NS; hwrite = 1; hsize = 3'd2; haddr = 32'h18;
        @(posedge hclk);
        #1;
        idle_inputs();
        hwdata = 32'hCAFEF00D;
        #2 hreset_n = 1'b0;
        #1;
        chk("rst_xfer_hreadyo", {31'b0, hreadyo}, 32'h1);
        chk("rst_xfer_hresp", {30'b0, hresp}, 32'h0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        hwdata = 32'h0;
        @(posedge hclk);
        #1;
        push(1, T_NS, 0, 3'd2, 32'h18, 32'h0);
        run_queue();
        chk("case5_no_commit", last_rd, 32'h0BADF00D);

        // Reset during a read data phase clears hrdata immediately
        hsel = 1; htrans = T_NS; hwrite = 0; hsize = 3'd2; haddr = 32'h18;
        @(posedge hclk);
        #1;
        idle_inputs();
        chk("rd_xfer_hrdata", hrdata, 32'h0BADF00D);
        #2 hreset_n = 1'b0;
        #1;
        chk("rst_rd_hrdata", hrdata, 32'h0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        repeat (2) @(posedge hclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb2_sram_slv.md
AHB2_SRAM_SLV -- requirements
Module: ahb2_sram_slv

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (memory = 2^ADDR_W x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per transfer, legal range 0..15.
REQ-003 SHALL use one clock, hclk; reset hreset_n is asynchronous and active-low.
REQ-004 hclk  input  1  AHB clock; all state changes on rising edge.
REQ-005 hreset_n  input  1  asynchronous active-low reset.
REQ-006 hsel  input  1  slave select, address phase.
REQ-007 haddr  input  32  byte address.
REQ-008 htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 hwrite  input  1  1 = write, 0 = read.
REQ-010 hsize  input  3  000 = 8b, 001 = 16b, 010 = 32b; other values illegal.
REQ-011 hburst, hprot  input  3, 4  accepted and ignored; each burst beat is an independent transfer.
REQ-012 hwdata  input  32  write data, data phase.
REQ-013 hreadyi  input  1  bus-wide HREADY; previous data phase done.
REQ-014 hrdata  output  32  read data.
REQ-015 hreadyo  output  1  this slave's HREADY.
REQ-016 hresp  output  2  OKAY = 00 or ERROR = 01 only; RETRY and SPLIT never driven.

Function
REQ-017 Transfer accepted on a rising edge only when hsel=1, hreadyi=1 and htrans is NONSEQ or SEQ; haddr, hwrite and hsize latched into data-phase registers.
REQ-018 hsel=1 with IDLE/BUSY, or hsel=0, or hreadyi=0: nothing accepted; a following data phase, if any, is zero-wait OKAY.
REQ-019 Illegal transfer: hsize > 010; 16b with haddr[0]=1; 32b with haddr[1:0]!=00; or haddr[31:ADDR_W+2] != 0.
REQ-020 Data-phase FSM states: IDLE, XFER, ERR1, ERR2; IDLE drives hreadyo=1, hresp=OKAY.
REQ-021 Legal accept -> XFER with counter = WAIT_CYCLES; hreadyo=0 while counter != 0, decrement each cycle; hreadyo=1 and hresp=OKAY when counter = 0.
REQ-022 Illegal accept -> ERR1 (hreadyo=0, hresp=ERROR) -> ERR2 (hreadyo=1, hresp=ERROR); no memory access occurs.
REQ-023 Any cycle with hreadyo=1 (IDLE, XFER completion, ERR2) samples the next address phase per REQ-017; next state is XFER, ERR1 or IDLE.
REQ-024 Write commits on the XFER completion edge; only byte lanes selected by latched haddr[1:0] and hsize are written, little-endian: lane k = hwdata[8k+7:8k].
REQ-025 Read: during XFER, hrdata = full 32-bit word at latched word address; otherwise hrdata = 0.
REQ-026 Word address = latched haddr[ADDR_W+1:2].
REQ-027 Read issued directly after a write to the same word returns the newly written data, with no extra wait state.
REQ-028 Back-to-back transfers with WAIT_CYCLES=0 complete one per cycle.

Reset
REQ-029 On hreset_n=0 asynchronously: FSM to IDLE, counter 0, hreadyo=1, hresp=OKAY, hrdata=0, data-phase registers cleared.
REQ-030 Reset mid-transfer aborts it; a pending write is not committed.
REQ-031 Memory contents are not reset and are undefined until written.

Configuration
REQ-032 Macro AHB2_SRAM_WAIT_EN: when defined, wait states per REQ-021 use WAIT_CYCLES.
REQ-033 Without AHB2_SRAM_WAIT_EN: WAIT_CYCLES is ignored, the counter is not implemented, every legal transfer is zero-wait, and ERROR handling is unchanged.

Verification
REQ-034 Case 1, WAIT_EN and WAIT_CYCLES=2: write 32b 0xDEADBEEF @0x10, then read @0x10 -> each data phase shows hreadyo 0,0,1; read hrdata=0xDEADBEEF, hresp=OKAY.
REQ-035 Case 2, byte write: 0xAA @0x13 onto word 0x11223344 -> read @0x10 returns 0xAA223344.
REQ-036 Case 3, illegal transfers: 32b @0x02, or haddr=0x00001000 with ADDR_W=10 -> ERR1/ERR2 sequence (hreadyo 0 then 1, hresp=01 both cycles); memory unchanged.
REQ-037 Case 4, no WAIT_EN: NONSEQ+SEQ write burst 0x0,0x4,0x8, then read burst of the same addresses -> one beat per cycle, hreadyo=1 throughout, data matches.
REQ-038 Case 5, hreadyi=0 with hsel=1 NONSEQ -> transfer ignored, FSM stays IDLE; hreset_n pulsed low during XFER write -> outputs return to reset values immediately, write not committed.
